cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the processor datapath. It succeeds the fixed 8-bit CLA and supports three things that block does not:
- arbitrary width in CHUNK-bit lookahead slices;
- one pipeline register per slice, so carry ripples between stages rather than within a cycle;
- ADD/SUB/ADC/SBB operations with carry, overflow and zero flags.

Operands enter and results leave through valid/ready handshakes, so the block sits between the operand-fetch and writeback stages.

## Interface
- WIDTH, 32, operand/result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 8, bits per lookahead slice and per pipeline stage; STAGES = WIDTH/CHUNK.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- in_op  in  2  operation: ADD, SUB, ADC, SBB (encodings in package).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in, used by ADC/SBB only.
- out_valid  out  1  result beat presented.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; for SUB/SBB, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  out_sum == 0.

## Operation
- Effective carry-in and B operand per op:
  - ADD: B, cin = 0.
  - SUB: ~B, cin = 1.
  - ADC: B, cin = in_cin.
  - SBB: ~B, cin = in_cin (in_cin = 1 means no borrow).
- Stage k (0..STAGES-1) runs a CHUNK-bit CLA on slice k, using the carry registered from stage k-1. Stage 0 uses the effective cin.
- Operand slices for higher stages are skewed through shift registers. Completed lower sum slices are carried forward alongside.
- Each stage holds a valid bit. Stage k registers slice k's sum and carry-out, the carry into its MSB (needed for overflow), and all earlier slices.
- Flags are computed from the final stage's registered values:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = NOR of all out_sum bits.
- Flow control is a global stall: advance = !out_valid || out_ready, and in_ready = advance.
  - On advance, every stage shifts one step.
  - On stall, all stage registers and valid bits hold, and out_* outputs hold stable.
- A beat accepted while in_valid && in_ready enters stage 0. A bubble (in_valid = 0) shifts a cleared valid bit.
- Results leave in the same order as operands entered. Nothing is dropped or duplicated.

## Timing
- Reset (rst_n low at a rising edge):
  - clears every stage valid bit;
  - drives out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0;
  - discards all in-flight beats.
- in_ready is 1 in the first cycle after reset.
- Latency: a beat accepted at edge t is presented on out_valid after edge t+STAGES-1 (STAGES cycles, counting the accept edge), provided there is no stall.
- Throughput: one beat per cycle while out_ready stays high.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists.
- Accept and retire in the same cycle are legal at full occupancy.
- STAGES = 1 degenerates to a single registered CLA with latency 1.

## Structure
- Package cla_pkg:
  - op encoding localparams: ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBB = 2'b11;
  - an op-to-(invert_b, cin_sel) decode function.
- Sub-module cla_slice: combinational CHUNK-bit lookahead slice with generate/propagate per bit. It has:
  - inputs a, b, cin;
  - outputs sum, cout, c_msb_in (carry into the slice MSB), and group G/P.
- The top level instantiates STAGES slices in a generate loop and owns all registers and handshake logic.

## Test plan
- WIDTH = 16, CHUNK = 8, out_ready = 1: ADD 0x00FF + 0x0001 -> after 2 cycles out_sum = 0x0100, cout = 0, ovf = 0, zero = 0. This checks the inter-stage carry.
- SUB 0x8000 − 0x0001 -> out_sum = 0x7FFF, cout = 1, ovf = 1. Then SUB 0x1234 − 0x1234 -> out_sum = 0x0000, cout = 1, zero = 1.
- ADD 0xFFFF + 0x0001 -> out_sum = 0x0000, cout = 1, zero = 1, ovf = 0. Then ADC 0x0001 + 0x0001 with cin = 1 -> 0x0003.
- Back-to-back stream of 8 beats with out_ready held low for cycles 3–5:
  - in_ready drops during the stall;
  - out_* stay stable;
  - all 8 results arrive in order with no loss.
- Reset asserted with 2 beats in flight -> the next cycle has out_valid = 0 and all outputs 0. The first beat after reset completes with correct latency.
- WIDTH = 32, CHUNK = 8: randomised ops checked against a reference model. Includes SBB 0x0 − 0x0 with cin = 0 -> 0xFFFFFFFF, cout = 0.

Source files
------------

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Operation encodings and operation decode shared by the
//             pipelined carry-lookahead adder/subtractor.
//  Contents : ADD/SUB/ADC/SBB encodings, carry-in source enum, decode struct,
//             decode_op() which maps an op to (invert_b, cin_sel).
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ADC = 2'b10;
    localparam logic [1:0] SBB = 2'b11;

    // Source of the carry injected into the least significant slice.
    typedef enum logic [1:0] {
        CIN_ZERO = 2'd0,
        CIN_ONE  = 2'd1,
        CIN_EXT  = 2'd2
    } cin_sel_e;

    typedef struct packed {
        logic     invert_b;
        cin_sel_e cin_sel;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [1:0] op);
        op_dec_t d;
        d.invert_b = 1'b0;
        d.cin_sel  = CIN_ZERO;
        case (op)
            ADD: begin d.invert_b = 1'b0; d.cin_sel = CIN_ZERO; end
            SUB: begin d.invert_b = 1'b1; d.cin_sel = CIN_ONE;  end
            ADC: begin d.invert_b = 1'b0; d.cin_sel = CIN_EXT;  end
            default: begin d.invert_b = 1'b1; d.cin_sel = CIN_EXT; end
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cla_slice
//  Purpose  : Combinational CHUNK-bit carry-lookahead slice.
//  Ports    : a, b     - slice operands (b already inverted for subtract)
//             cin      - carry into bit 0
//             sum      - slice sum
//             cout     - carry out of the slice MSB
//             c_msb_in - carry into the slice MSB (signed overflow)
//             grp_g    - group generate
//             grp_p    - group propagate
//  Revision : 1.0  initial release
// ============================================================================
module cla_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in,
    output logic             grp_g,
    output logic             grp_p
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             acc;
    logic             pp;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products: c[i+1] = g[i] | p[i]g[i-1] | ...
    // | p[i]..p[0]cin, built from bit i downwards with a running propagate.
    always_comb begin
        c     = '0;
        acc   = 1'b0;
        pp    = 1'b1;
        grp_g = 1'b0;
        c[0]  = cin;
        for (int i = 0; i < CHUNK; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (cin & pp);
            if (i == CHUNK - 1) begin
                grp_g = acc;
            end
        end
        sum      = p ^ c[CHUNK-1:0];
        cout     = c[CHUNK];
        c_msb_in = c[CHUNK-1];
        grp_p    = &p;
    end

endmodule
`default_nettype wire

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_addsub
//  Purpose  : Pipelined carry-lookahead adder/subtractor, one CHUNK-bit slice
//             per stage, with valid/ready flow control and C/V/Z flags.
//  Ports    : clk, rst_n (synchronous, active-low)
//             in_valid/in_ready, in_op, in_a, in_b, in_cin  - operand beat
//             out_valid/out_ready, out_sum, out_cout, out_ovf, out_zero
//  Revision : 1.0  initial release
// ============================================================================
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = WIDTH / CHUNK;

    op_dec_t          dec;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             advance;

    always_comb begin
        dec   = decode_op(in_op);
        b_eff = dec.invert_b ? ~in_b : in_b;
        case (dec.cin_sel)
            CIN_ZERO: cin_eff = 1'b0;
            CIN_ONE:  cin_eff = 1'b1;
            default:  cin_eff = in_cin;
        endcase
    end

    // Global stall: the whole pipe moves only when the output slot frees up.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = (k + 1) * CHUNK;   // sum bits completed here
        localparam int OW = WIDTH - SW;        // operand bits still pending

        logic [CHUNK-1:0] sa;
        logic [CHUNK-1:0] sb;
        logic             sc;
        logic [CHUNK-1:0] s_sum;
        logic             s_cout;
        logic             s_cmsb;
        logic             s_g;
        logic             s_p;
        logic [2:0]       side_unused;
        logic [SW-1:0]    sum_d;
        logic [SW-1:0]    sum_q;
        logic             vld_d;
        logic             vld_q;
        logic             cy_q;

        if (k == 0) begin : g_head
            assign sa    = in_a[CHUNK-1:0];
            assign sb    = b_eff[CHUNK-1:0];
            assign sc    = cin_eff;
            assign vld_d = in_valid;
            assign sum_d = s_sum;
        end else begin : g_tail
            assign sa    = g_stage[k-1].g_fwd.a_q[CHUNK-1:0];
            assign sb    = g_stage[k-1].g_fwd.b_q[CHUNK-1:0];
            assign sc    = g_stage[k-1].cy_q;
            assign vld_d = g_stage[k-1].vld_q;
            assign sum_d = {s_sum, g_stage[k-1].sum_q};
        end

        cla_slice #(
            .CHUNK    (CHUNK)
        ) u_slice (
            .a        (sa),
            .b        (sb),
            .cin      (sc),
            .sum      (s_sum),
            .cout     (s_cout),
            .c_msb_in (s_cmsb),
            .grp_g    (s_g),
            .grp_p    (s_p)
        );

        // Group G/P are not needed between registered stages, and the MSB
        // carry matters only in the last stage.
        assign side_unused = {s_cmsb, s_g, s_p};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_d;
                sum_q <= sum_d;
                cy_q  <= s_cout;
            end
        end

        // Skew registers carrying the not-yet-added upper operand slices.
        if (OW > 0) begin : g_fwd
            logic [OW-1:0] a_d;
            logic [OW-1:0] b_d;
            logic [OW-1:0] a_q;
            logic [OW-1:0] b_q;

            if (k == 0) begin : g_src_in
                assign a_d = in_a[WIDTH-1:CHUNK];
                assign b_d = b_eff[WIDTH-1:CHUNK];
            end else begin : g_src_prev
                assign a_d = g_stage[k-1].g_fwd.a_q[OW+CHUNK-1:CHUNK];
                assign b_d = g_stage[k-1].g_fwd.b_q[OW+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic cmsb_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                end else if (advance) begin
                    cmsb_q <= s_cmsb;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign out_sum   = g_stage[STAGES-1].sum_q;
    assign out_cout  = g_stage[STAGES-1].cy_q;
    assign out_ovf   = g_stage[STAGES-1].g_last.cmsb_q ^ g_stage[STAGES-1].cy_q;
    // Qualified by valid so the flag reads 0 out of reset, not NOR(0) = 1.
    assign out_zero  = out_valid & ~|out_sum;

endmodule
`default_nettype wire
